axi_wr_responder: RTL and testbench

AXI_WR_RESPONDER -- requirements
Module: axi_wr_responder

---
 rtl/axi_wr_responder.sv | 98 +++++++++
 tb/tb_axi_wr_responder.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_wr_responder.sv
// AXI write-channel responder: accepts one AW burst at a time, streams W beats
// into a simple memory write port, and pulses wr_done once per completed burst.
module axi_wr_responder #(
    parameter int unsigned AXI_DATA_WIDTH = 128,
    parameter int unsigned AXI_ADDR_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      axi_aw_req_en,
    input  logic [7:0]                axi_aw_burst_len,
    input  logic [AXI_ADDR_WIDTH-1:0] axi_aw_addr,
    output logic                      axi_aw_ready,
    input  logic [AXI_DATA_WIDTH-1:0] axi_w_data,
    input  logic                      axi_w_valid,
    input  logic                      axi_w_last,
    output logic                      axi_w_ready,
    input  logic                      w_stall,
    output logic                      mem_wr_en,
    output logic [AXI_ADDR_WIDTH-1:0] mem_wr_addr,
    output logic [AXI_DATA_WIDTH-1:0] mem_wr_data,
    output logic                      wr_done,
    output logic [15:0]               burst_cnt,
    output logic                      last_err,
    output logic                      addr_err
);

    localparam int unsigned BYTES = AXI_DATA_WIDTH / 8;
    localparam int unsigned LSB   = $clog2(BYTES);

    typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;

    state_t                    state;
    logic [7:0]                len;
    logic [7:0]                beat_cnt;
    logic [AXI_ADDR_WIDTH-1:0] addr;
    logic                      w_hs;
    logic                      final_beat;

    assign axi_w_ready = (state == DATA) && !w_stall;
    assign w_hs        = axi_w_ready && axi_w_valid;
    assign final_beat  = (beat_cnt == len);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            axi_aw_ready <= 1'b0;
            len          <= '0;
            beat_cnt     <= '0;
            addr         <= '0;
            mem_wr_en    <= 1'b0;
            mem_wr_addr  <= '0;
            mem_wr_data  <= '0;
            wr_done      <= 1'b0;
            burst_cnt    <= '0;
            last_err     <= 1'b0;
            addr_err     <= 1'b0;
        end else begin
            mem_wr_en <= 1'b0;
            wr_done   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (axi_aw_req_en && axi_aw_ready) begin
                        state        <= DATA;
                        axi_aw_ready <= 1'b0;
                        len          <= axi_aw_burst_len;
                        addr         <= axi_aw_addr;
                        beat_cnt     <= '0;
                        if (axi_aw_addr[LSB-1:0] != '0) addr_err <= 1'b1;
                    end else begin
                        axi_aw_ready <= 1'b1;
                    end
                end
                DATA: begin
                    if (w_hs) begin
                        mem_wr_en   <= 1'b1;
                        mem_wr_addr <= addr;
                        mem_wr_data <= axi_w_data;
                        addr        <= addr + AXI_ADDR_WIDTH'(BYTES);
                        beat_cnt    <= beat_cnt + 8'd1;
                        if (axi_w_last != final_beat) last_err <= 1'b1;
                        // Termination follows the beat counter; axi_w_last is only audited.
                        if (final_beat) begin
                            state     <= RESP;
                            wr_done   <= 1'b1;
                            burst_cnt <= burst_cnt + 16'd1;
                        end
                    end
                end
                RESP: begin
                    state        <= IDLE;
                    axi_aw_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_wr_responder.sv
// Randomized bench for axi_wr_responder: background AW/W drivers, a transaction-level
// model of expected memory writes, and a per-cycle compare process.
module tb_axi_wr_responder;

    logic         clk;
    logic         reset;
    logic         axi_aw_req_en;
    logic [7:0]   axi_aw_burst_len;
    logic [31:0]  axi_aw_addr;
    logic         axi_aw_ready;
    logic [127:0] axi_w_data;
    logic         axi_w_valid;
    logic         axi_w_last;
    logic         axi_w_ready;
    logic         w_stall;
    logic         mem_wr_en;
    logic [31:0]  mem_wr_addr;
    logic [127:0] mem_wr_data;
    logic         wr_done;
    logic [15:0]  burst_cnt;
    logic         last_err;
    logic         addr_err;

    axi_wr_responder #(.AXI_DATA_WIDTH(128), .AXI_ADDR_WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .axi_aw_req_en(axi_aw_req_en), .axi_aw_burst_len(axi_aw_burst_len),
        .axi_aw_addr(axi_aw_addr), .axi_aw_ready(axi_aw_ready),
        .axi_w_data(axi_w_data), .axi_w_valid(axi_w_valid), .axi_w_last(axi_w_last),
        .axi_w_ready(axi_w_ready), .w_stall(w_stall),
        .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .wr_done(wr_done), .burst_cnt(burst_cnt), .last_err(last_err), .addr_err(addr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct { logic [31:0] addr; logic [7:0] len; } aw_t;
    typedef struct { int len; int early; bit drop; } wb_t;
    typedef struct { logic [31:0] addr; bit last; } beat_t;

    aw_t aw_q[$];
    wb_t w_q[$];
    int  valid_pct = 100;
    int  stall_pct = 0;

    // AW driver: holds a request until accepted, so later requests queue up.
    initial begin
        axi_aw_req_en = 1'b0; axi_aw_burst_len = '0; axi_aw_addr = '0;
        forever begin
            @(posedge clk); #1;
            if (aw_q.size() > 0 && reset) begin
                axi_aw_req_en    = 1'b1;
                axi_aw_addr      = aw_q[0].addr;
                axi_aw_burst_len = aw_q[0].len;
            end else begin
                axi_aw_req_en    = 1'b0;
                axi_aw_addr      = $urandom;
                axi_aw_burst_len = 8'($urandom);
            end
            @(negedge clk);
            if (!reset) aw_q.delete();
            else if (axi_aw_req_en && axi_aw_ready) void'(aw_q.pop_front());
        end
    end

    // W driver: counts its own beats to place w_last; noise on w_valid while idle.
    int wbeat = 0;
    initial begin
        axi_w_valid = 1'b0; axi_w_last = 1'b0; axi_w_data = '0; w_stall = 1'b0;
        forever begin
            @(posedge clk); #1;
            w_stall    = ($urandom_range(0, 99) < stall_pct);
            axi_w_data = {$urandom, $urandom, $urandom, $urandom};
            if (w_q.size() > 0 && reset) begin
                axi_w_valid = ($urandom_range(0, 99) < valid_pct);
                axi_w_last  = ((wbeat == w_q[0].len) && !w_q[0].drop) || (wbeat == w_q[0].early);
            end else begin
                axi_w_valid = 1'($urandom_range(0, 1));
                axi_w_last  = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            if (!reset) begin
                w_q.delete(); wbeat = 0;
            end else if (w_q.size() > 0 && axi_w_valid && axi_w_ready) begin
                if (wbeat == w_q[0].len) begin void'(w_q.pop_front()); wbeat = 0; end
                else wbeat++;
            end
        end
    end

    // Model: an accepted AW expands into its full list of beat addresses.
    beat_t        m_q[$];
    logic         e_aw = 0, e_wr = 0, e_done = 0, e_lerr = 0, e_aerr = 0;
    logic [15:0]  e_cnt = 0;
    logic [31:0]  e_waddr = 0;
    logic [127:0] e_wdata = 0;
    int           cyc = 0;
    logic [31:0]  seen_addr[$];
    int           done_cyc[$];
    int           aw_cyc[$];

    always @(negedge clk) begin
        logic  n_aw, n_wr, n_done;
        beat_t b;
        cyc++;
        if (!reset) begin
            e_aw = 0; e_wr = 0; e_done = 0; e_lerr = 0; e_aerr = 0; e_cnt = 0;
        end
        chk("aw_ready", 128'(axi_aw_ready), 128'(e_aw));
        chk("w_ready", 128'(axi_w_ready), 128'(reset && m_q.size() > 0 && !w_stall));
        chk("mem_wr_en", 128'(mem_wr_en), 128'(e_wr));
        if (e_wr) begin
            chk("mem_wr_addr", 128'(mem_wr_addr), 128'(e_waddr));
            chk("mem_wr_data", mem_wr_data, e_wdata);
        end
        if (!reset) begin
            chk("rst_mem_wr_addr", 128'(mem_wr_addr), 128'(0));
            chk("rst_mem_wr_data", mem_wr_data, 128'(0));
        end
        chk("wr_done", 128'(wr_done), 128'(e_done));
        chk("burst_cnt", 128'(burst_cnt), 128'(e_cnt));
        chk("last_err", 128'(last_err), 128'(e_lerr));
        chk("addr_err", 128'(addr_err), 128'(e_aerr));

        if (mem_wr_en) seen_addr.push_back(mem_wr_addr);
        if (wr_done) done_cyc.push_back(cyc);
        if (axi_aw_req_en && axi_aw_ready && reset) aw_cyc.push_back(cyc);

        if (!reset) begin
            m_q.delete();
        end else begin
            n_aw = 0; n_wr = 0; n_done = 0;
            if (m_q.size() == 0 && e_aw && axi_aw_req_en) begin
                for (int i = 0; i <= int'(axi_aw_burst_len); i++) begin
                    b.addr = axi_aw_addr + 32'(i * 16);
                    b.last = (i == int'(axi_aw_burst_len));
                    m_q.push_back(b);
                end
                if (axi_aw_addr[3:0] != 4'h0) e_aerr = 1;
            end else if (m_q.size() > 0) begin
                if (axi_w_valid && !w_stall) begin
                    b = m_q.pop_front();
                    n_wr = 1; e_waddr = b.addr; e_wdata = axi_w_data;
                    if (axi_w_last != b.last) e_lerr = 1;
                    if (b.last) begin n_done = 1; e_cnt = e_cnt + 16'd1; end
                end
            end else begin
                n_aw = 1;
            end
            e_aw = n_aw; e_wr = n_wr; e_done = n_done;
        end
    end

    function automatic logic [31:0] sa(input int i);
        if (i < seen_addr.size()) return seen_addr[i];
        return 32'hDEAD_BEEF;
    endfunction

    task automatic clear_logs();
        seen_addr.delete(); done_cyc.delete(); aw_cyc.delete();
    endtask

    task automatic burst(input logic [31:0] a, input int len, input int early, input bit drop);
        aw_t aw; wb_t w;
        aw.addr = a; aw.len = 8'(len);
        w.len = len; w.early = early; w.drop = drop;
        aw_q.push_back(aw); w_q.push_back(w);
    endtask

    task automatic drain(input int budget);
        bit ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (aw_q.size() == 0 && w_q.size() == 0) begin ok = 1; break; end
        end
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL drain_timeout: got busy expected idle within %0d cycles", budget);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic do_reset(input int cycles);
        @(posedge clk); #1; reset = 0;
        repeat (cycles) @(negedge clk);
        chk("rst_aw_ready", 128'(axi_aw_ready), 128'(0));
        chk("rst_mem_wr_en", 128'(mem_wr_en), 128'(0));
        chk("rst_wr_done", 128'(wr_done), 128'(0));
        chk("rst_burst_cnt", 128'(burst_cnt), 128'(0));
        chk("rst_errs", 128'({last_err, addr_err}), 128'(0));
        @(posedge clk); #1; reset = 1;
        @(negedge clk);
        chk("rel_aw_ready_0", 128'(axi_aw_ready), 128'(0));
        @(negedge clk);
        chk("rel_aw_ready_1", 128'(axi_aw_ready), 128'(1));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 0;
        repeat (2) @(negedge clk);
        do_reset(2);

        // Single beat
        clear_logs(); valid_pct = 100; stall_pct = 0;
        burst(32'h100, 0, -1, 0); drain(100);
        chk("single_writes", 128'(seen_addr.size()), 128'(1));
        chk("single_addr", 128'(sa(0)), 128'(32'h100));
        chk("single_done", 128'(done_cyc.size()), 128'(1));
        chk("single_cnt", 128'(burst_cnt), 128'(1));
        chk("single_errs", 128'({last_err, addr_err}), 128'(0));

        // Full 256-beat burst with random stalls
        clear_logs(); valid_pct = 80; stall_pct = 50;
        burst(32'h0, 255, -1, 0); drain(5000);
        chk("full_writes", 128'(seen_addr.size()), 128'(256));
        chk("full_addr1", 128'(sa(1)), 128'(32'h10));
        chk("full_addr255", 128'(sa(255)), 128'(32'hFF0));
        chk("full_done", 128'(done_cyc.size()), 128'(1));

        // Back-to-back queued requests
        clear_logs(); valid_pct = 100; stall_pct = 0;
        burst(32'h400, 3, -1, 0); burst(32'h800, 3, -1, 0); drain(200);
        chk("b2b_writes", 128'(seen_addr.size()), 128'(8));
        chk("b2b_cnt", 128'(burst_cnt), 128'(4));
        chk("b2b_aw_count", 128'(aw_cyc.size()), 128'(2));
        chk("b2b_turnaround",
            128'((aw_cyc.size() > 1 && done_cyc.size() > 0) ? aw_cyc[1] - done_cyc[0] : -1),
            128'(1));
        chk("b2b_second_addr", 128'(sa(4)), 128'(32'h800));

        // Early w_last, then unaligned address
        clear_logs();
        burst(32'h300, 3, 2, 0); drain(200);
        chk("early_writes", 128'(seen_addr.size()), 128'(4));
        chk("early_last_err", 128'(last_err), 128'(1));
        chk("early_addr_err", 128'(addr_err), 128'(0));
        clear_logs();
        burst(32'h104, 0, -1, 0); drain(200);
        chk("unal_addr", 128'(sa(0)), 128'(32'h104));
        chk("unal_errs_sticky", 128'({last_err, addr_err}), 128'(2'b11));

        // Address wrap
        clear_logs();
        burst(32'hFFFF_FFF0, 1, -1, 0); drain(200);
        chk("wrap_addr0", 128'(sa(0)), 128'(32'hFFFF_FFF0));
        chk("wrap_addr1", 128'(sa(1)), 128'(32'h0));

        // Reset in the middle of a burst
        clear_logs();
        burst(32'h500, 3, -1, 0);
        for (int i = 0; i < 100 && seen_addr.size() == 0; i++) @(negedge clk);
        chk("abort_started", 128'(seen_addr.size() > 0), 128'(1));
        do_reset(2);
        chk("abort_no_done", 128'(done_cyc.size()), 128'(0));
        chk("abort_writes", 128'(seen_addr.size() < 4), 128'(1));
        clear_logs();
        burst(32'h600, 2, -1, 0); drain(200);
        chk("resume_writes", 128'(seen_addr.size()), 128'(3));
        chk("resume_cnt", 128'(burst_cnt), 128'(1));

        // Randomized bursts with protocol noise
        for (int n = 0; n < 25; n++) begin
            valid_pct = $urandom_range(40, 100);
            stall_pct = $urandom_range(0, 60);
            for (int k = 0; k < int'($urandom_range(1, 3)); k++) begin
                logic [31:0] a;
                int l;
                a = $urandom;
                if ($urandom_range(0, 9) != 0) a[3:0] = 4'h0;
                l = $urandom_range(0, 31);
                burst(a, l,
                      ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 31)) : -1,
                      ($urandom_range(0, 9) == 0));
            end
            drain(2000);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
